// File: rtl/oled_spi_tx_if.sv
// oled_spi_tx_if: upstream byte handshake into the OLED SPI transmitter.
// The register wrapper (master) offers a byte plus its DC flag.
// The transmitter (slave) accepts the byte on in_valid && in_ready.
interface oled_spi_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dc;

  modport master (output in_valid, output in_data, output in_dc, input in_ready);
  modport slave  (input in_valid, input in_data, input in_dc, output in_ready);
endinterface

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: byte-level SPI transmit engine for SSD1331-class OLED panels.
// Bytes are buffered in a small FIFO and shifted out in SPI mode 0, MSB first.
// The block drives CS, DC and the panel reset pin, and runs the power-on reset pulse sequence.
// Build option OLED_TX_CS_HOLD_EN: when defined, consecutive bytes with the same DC value
// keep oled_cs low through the inter-byte gap (burst mode). When undefined, every byte is
// framed by its own CS pulse.
module oled_spi_tx #(
  parameter int CLK_DIV      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int RST_LOW_CYC  = 160,
  parameter int RST_WAIT_CYC = 160
) (
  input  logic         clk,
  input  logic         reset,
  oled_spi_tx_if.slave up,
  input  logic         hw_rst_req,
  output logic         busy,
  output logic         oled_sclk,
  output logic         oled_mosi,
  output logic         oled_cs,
  output logic         oled_dc,
  output logic         oled_res
);

  localparam int          AW            = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ZERO      = {(AW + 1){1'b0}};
  localparam logic [AW:0] PTR_ONE       = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] DIV_LAST      = 16'(CLK_DIV - 1);
  localparam logic [15:0] RST_LOW_LAST  = 16'(RST_LOW_CYC - 1);
  localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_RST_LOW  = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_LOAD     = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;       // reset-sequence length or SCLK half-period/gap length
  logic [2:0]  bit_cnt_r;   // bits still to send after the one on mosi
  logic [7:0]  sh_r;        // remaining bits of the current byte, next one at [7]
  logic        rst_pend_r;  // panel reset requested, waiting for the FIFO to drain

  // FIFO entry layout: {dc, data}
  logic [8:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [8:0]  head_s;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        in_seq_s;

  assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign in_seq_s = (state_r == ST_RST_LOW) || (state_r == ST_RST_WAIT);
  assign pop_s    = (state_r == ST_LOAD);

  // New bytes are held off while a panel reset is pending, so they are sent only after the reset sequence.
  assign up.in_ready = !full_s && !in_seq_s && !rst_pend_r;
  assign push_s      = up.in_valid && up.in_ready;
  assign busy        = !empty_s || (state_r != ST_IDLE) || rst_pend_r;

  // FIFO storage: write the pushed byte and its DC flag
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {up.in_dc, up.in_data};
    end
  end

  // FIFO pointers: advance on push and on the LOAD pop; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Transmit FSM: reset sequencing, byte load, bit shifting, inter-byte gap; all pin outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RST_LOW;
      cnt_r      <= 16'd0;
      bit_cnt_r  <= 3'd0;
      sh_r       <= 8'h00;
      rst_pend_r <= 1'b0;
      oled_sclk  <= 1'b0;
      oled_mosi  <= 1'b0;
      oled_cs    <= 1'b1;
      oled_dc    <= 1'b0;
      oled_res   <= 1'b0;
    end else begin
      // Repeated requests merge into the one latched flag.
      if (hw_rst_req) begin
        rst_pend_r <= 1'b1;
      end
      case (state_r)
        ST_RST_LOW: begin
          if (cnt_r == RST_LOW_LAST) begin
            cnt_r    <= 16'd0;
            oled_res <= 1'b1;
            state_r  <= ST_RST_WAIT;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_RST_WAIT: begin
          if (cnt_r == RST_WAIT_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_IDLE: begin
          if (!empty_s) begin
            // The frame opens as LOAD is entered, so CS/DC/bit7 are already valid during LOAD.
            state_r   <= ST_LOAD;
            oled_cs   <= 1'b0;
            oled_dc   <= head_s[8];
            oled_mosi <= head_s[7];
            sh_r      <= {head_s[6:0], 1'b0};
          end else if (rst_pend_r) begin
            state_r    <= ST_RST_LOW;
            cnt_r      <= 16'd0;
            oled_res   <= 1'b0;
            rst_pend_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r   <= ST_SHIFT;
          cnt_r     <= 16'd0;
          bit_cnt_r <= 3'd7;
        end
        ST_SHIFT: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r <= 16'd0;
            if (!oled_sclk) begin
              oled_sclk <= 1'b1;
            end else begin
              // Falling edge: the only point where mosi may change.
              oled_sclk <= 1'b0;
              if (bit_cnt_r == 3'd0) begin
                state_r <= ST_GAP;
`ifdef OLED_TX_CS_HOLD_EN
                // Keep the frame open only if the next byte is already queued with the same DC.
                oled_cs <= !(!empty_s && (head_s[8] == oled_dc));
`else
                oled_cs <= 1'b1;
`endif
              end else begin
                bit_cnt_r <= bit_cnt_r - 3'd1;
                oled_mosi <= sh_r[7];
                sh_r      <= {sh_r[6:0], 1'b0};
              end
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r <= 16'd0;
            if (!empty_s) begin
              state_r   <= ST_LOAD;
              oled_cs   <= 1'b0;
              oled_dc   <= head_s[8];
              oled_mosi <= head_s[7];
              sh_r      <= {head_s[6:0], 1'b0};
            end else begin
              state_r <= ST_IDLE;
              oled_cs <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r   <= ST_RST_LOW;
          cnt_r     <= 16'd0;
          oled_sclk <= 1'b0;
          oled_cs   <= 1'b1;
          oled_res  <= 1'b0;
        end
      endcase
    end
  end

endmodule
